// File: rtl/ucode_sequencer.sv
// ucode_sequencer
//   Microcode sequencer. It holds the micro-program counter (upc), addresses an
//   external combinational microcode ROM and dispatches on the instruction
//   opcode. Every microinstruction runs one setup cycle (phase 0) and then one
//   or more M cycles (phase 1). Wait microinstructions stay in M until
//   mem_ready is seen.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   instr      current instruction register (opcode source for DISPATCH)
//   cond_in    condition result, sampled in the completing cycle of a CJUMP
//   mem_ready  memory completion, honoured only in M of a wait microword
//   udata      ROM data for uaddr, valid in the same cycle
//   uaddr      ROM address (upc; forced to 0 while in reset)
//   ctrl       control field: level bits pass through, strobe bits are gated
//   mem_req    memory request (wait bit of the current microword)
//   phase      0 = setup, 1 = M (strobe) phase
//   ibound     setup phase at upc 0 (instruction boundary)
//
// Microword layout: [1:0] nxt, [2] wait, [UAW+2:3] target, [UW-1:UAW+3] ctrl.
module ucode_sequencer #(
    parameter int IW  = 16,
    parameter int OPW = 6,
    parameter int UAW = 8,
    parameter int UW  = 40,
    parameter logic [UW-UAW-4:0] STROBE_MASK = '1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IW-1:0]        instr,
    input  logic                 cond_in,
    input  logic                 mem_ready,
    input  logic [UW-1:0]        udata,
    output logic [UAW-1:0]       uaddr,
    output logic [UW-UAW-4:0]    ctrl,
    output logic                 mem_req,
    output logic                 phase,
    output logic                 ibound
);

    localparam int CW = UW - UAW - 3;
    localparam int SW = UAW + OPW;

    localparam logic [1:0] NXT_SEQ      = 2'd0;
    localparam logic [1:0] NXT_DISPATCH = 2'd1;
    localparam logic [1:0] NXT_JUMP     = 2'd2;
    localparam logic [1:0] NXT_CJUMP    = 2'd3;

    localparam logic [0:0] PH_SETUP = 1'b0;
    localparam logic [0:0] PH_M     = 1'b1;

    logic [UAW-1:0] upc_reg;
    logic [UAW-1:0] upc_next;
    logic [0:0]     phase_reg;
    logic [0:0]     phase_next;

    // Microword fields
    logic [1:0]     u_nxt;
    logic           u_wait;
    logic [UAW-1:0] u_target;
    logic [CW-1:0]  u_ctrl;

    assign u_nxt    = udata[1:0];
    assign u_wait   = udata[2];
    assign u_target = udata[UAW+2:3];
    assign u_ctrl   = udata[UW-1:UAW+3];

    // Opcode: long form takes OPW bits below the form bit, short form takes
    // two bits zero-extended.
    logic [OPW-1:0] opcode;
    always_comb begin
        opcode = '0;
        if (instr[IW-1]) begin
            opcode = instr[IW-2 -: OPW];
        end else begin
            opcode[1:0] = instr[IW-2 -: 2];
        end
    end

    // Operand bits of instr below the opcode are not decoded here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[IW-2-OPW:0];

    // Dispatch address: table base plus opcode, wrapped to the upc width.
    logic [SW-1:0]  dispatch_sum;
    logic [UAW-1:0] upc_inc;
    logic [UAW-1:0] next_addr;
    logic           unused_sum_hi;

    assign dispatch_sum  = SW'(u_target) + SW'(opcode);
    assign unused_sum_hi = ^dispatch_sum[SW-1:UAW];
    assign upc_inc       = upc_reg + UAW'(1);

    always_comb begin
        next_addr = upc_inc;
        case (u_nxt)
            NXT_SEQ:      next_addr = upc_inc;
            NXT_DISPATCH: next_addr = dispatch_sum[UAW-1:0];
            NXT_JUMP:     next_addr = u_target;
            NXT_CJUMP:    next_addr = cond_in ? u_target : upc_inc;
            default:      next_addr = upc_inc;
        endcase
    end

    // Reset is folded into the output gating so that in the very first
    // reset cycle (before the state has been cleared) nothing leaks out.
    logic in_m;
    logic complete;

    assign in_m     = reset && (phase_reg == PH_M);
    assign complete = in_m && (!u_wait || mem_ready);

    always_comb begin
        upc_next   = upc_reg;
        phase_next = phase_reg;
        if (phase_reg == PH_SETUP) begin
            // mem_ready is ignored in setup: M always follows.
            phase_next = PH_M;
        end else if (complete) begin
            upc_next   = next_addr;
            phase_next = PH_SETUP;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            upc_reg   <= '0;
            phase_reg <= PH_SETUP;
        end else begin
            upc_reg   <= upc_next;
            phase_reg <= phase_next;
        end
    end

    assign uaddr   = reset ? upc_reg : '0;
    assign phase   = in_m;
    assign ibound  = !in_m && (uaddr == '0);
    assign mem_req = reset && u_wait;

    // Strobe bits fire only in the completing cycle; level bits pass through.
    genvar gi;
    generate
        for (gi = 0; gi < CW; gi++) begin : g_ctrl
            if (STROBE_MASK[gi]) begin : g_strobe
                assign ctrl[gi] = u_ctrl[gi] && complete;
            end else begin : g_level
                assign ctrl[gi] = u_ctrl[gi];
            end
        end
    endgenerate

endmodule

// File: tb/tb_ucode_sequencer.sv
// Self-checking bench for ucode_sequencer. A behavioural ROM feeds the DUT.
// The reference model steps one whole microinstruction at a time: it knows the
// cycle count (2 + stalls), where the strobe pulse lands and the next address
// computed from the microword rules with integer arithmetic.
module tb_ucode_sequencer;

    localparam int IW    = 16;
    localparam int OPW   = 6;
    localparam int UAW   = 8;
    localparam int UW    = 40;
    localparam int CW    = UW - UAW - 3;
    localparam int DEPTH = 1 << UAW;
    localparam logic [CW-1:0] SMASK = 29'h15555555;

    localparam logic [1:0] SEQ  = 2'd0;
    localparam logic [1:0] DISP = 2'd1;
    localparam logic [1:0] JMP  = 2'd2;
    localparam logic [1:0] CJ   = 2'd3;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [IW-1:0]   instr = '0;
    logic            cond_in = 1'b0;
    logic            mem_ready = 1'b0;
    logic [UW-1:0]   udata;
    logic [UAW-1:0]  uaddr;
    logic [CW-1:0]   ctrl;
    logic            mem_req;
    logic            phase;
    logic            ibound;

    logic [UW-1:0]   rom [0:DEPTH-1];
    int              m_upc = 0;
    int              checks = 0;
    int              failures = 0;

    assign udata = rom[uaddr];

    always #5 clk = ~clk;

    ucode_sequencer #(
        .IW(IW), .OPW(OPW), .UAW(UAW), .UW(UW), .STROBE_MASK(SMASK)
    ) dut (
        .clk(clk), .reset(reset), .instr(instr), .cond_in(cond_in),
        .mem_ready(mem_ready), .udata(udata), .uaddr(uaddr), .ctrl(ctrl),
        .mem_req(mem_req), .phase(phase), .ibound(ibound)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [UW-1:0] mk(input logic [1:0] n, input logic wt,
                                         input logic [UAW-1:0] t, input logic [CW-1:0] c);
        return {c, t, wt, n};
    endfunction

    function automatic int opcode_of(input logic [IW-1:0] i);
        if (i[IW-1]) return int'((i >> (IW - 1 - OPW)) % (1 << OPW));
        return int'((i >> (IW - 3)) % 4);
    endfunction

    // Expected outputs for one cycle of the microinstruction at m_upc.
    task automatic expect_cycle(input string tag, input int ph, input bit strobe,
                                input logic [UW-1:0] w, input int wt);
        logic [CW-1:0] ctl;
        ctl = CW'(w >> (UAW + 3));
        check({tag, "_uaddr"},  64'(uaddr),   64'(m_upc));
        check({tag, "_phase"},  64'(phase),   64'(ph));
        check({tag, "_ibound"}, 64'(ibound),  64'((ph == 0) && (m_upc == 0)));
        check({tag, "_memreq"}, 64'(mem_req), 64'(wt));
        check({tag, "_ctrl"},   64'(ctrl),    64'(strobe ? ctl : (ctl & ~SMASK)));
    endtask

    // While reset is low: address 0, setup, no strobes, no request.
    task automatic expect_reset(input string tag);
        logic [CW-1:0] ctl;
        ctl = CW'(rom[0] >> (UAW + 3));
        check({tag, "_uaddr"},  64'(uaddr),   64'(0));
        check({tag, "_phase"},  64'(phase),   64'(0));
        check({tag, "_ibound"}, 64'(ibound),  64'(1));
        check({tag, "_memreq"}, 64'(mem_req), 64'(0));
        check({tag, "_ctrl"},   64'(ctrl),    64'(ctl & ~SMASK));
    endtask

    // Runs one microinstruction from its setup cycle. Entered just after the
    // edge that starts setup; returns just after the edge that starts the next.
    task automatic run_uinstr(input logic [IW-1:0] ins, input bit c, input int stalls);
        logic [UW-1:0] w;
        int nxt, wt, tgt, ns, nxt_upc, cycles;
        w   = rom[m_upc];
        nxt = int'(w % 4);
        wt  = int'((w >> 2) % 2);
        tgt = int'((w >> 3) % DEPTH);
        ns  = (wt == 1) ? stalls : 0;
        instr     = ins;
        cond_in   = 1'($urandom_range(0, 1));
        mem_ready = 1'($urandom_range(0, 1));
        #1 expect_cycle("setup", 0, 1'b0, w, wt);
        @(posedge clk); #1;
        for (int s = 0; s < ns; s++) begin
            mem_ready = 1'b0;
            cond_in   = 1'($urandom_range(0, 1));
            #1 expect_cycle("stall", 1, 1'b0, w, wt);
            @(posedge clk); #1;
        end
        mem_ready = (wt == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        cond_in   = c;
        #1 expect_cycle("complete", 1, 1'b1, w, wt);
        case (nxt)
            0:       nxt_upc = (m_upc + 1) % DEPTH;
            1:       nxt_upc = (tgt + opcode_of(ins)) % DEPTH;
            2:       nxt_upc = tgt;
            default: nxt_upc = c ? tgt : (m_upc + 1) % DEPTH;
        endcase
        cycles = 2 + ns;
        $display("uinstr upc=%0d nxt=%0d wait=%0d instr=%h cond=%0d cycles=%0d -> upc=%0d",
                 m_upc, nxt, wt, ins, c, cycles, nxt_upc);
        m_upc = nxt_upc;
        @(posedge clk); #1;
    endtask

    logic [63:0] rnd;

    initial begin
        for (int i = 0; i < DEPTH; i++) rom[i] = '0;

        // Reset held for three cycles with a waiting, all-strobe word at 0.
        rom[0] = mk(SEQ, 1'b1, 8'd0, '1);
        repeat (3) begin
            @(posedge clk); #1;
            mem_ready = 1'b1;
            #1 expect_reset("reset");
        end
        rom[0] = mk(SEQ, 1'b0, 8'd0, '1);
        reset = 1'b1;
        m_upc = 0;
        run_uinstr(16'h0000, 1'b0, 0);             // -> 1

        // Dispatch on long and short opcodes.
        rom[1]  = mk(JMP, 1'b0, 8'd0, 29'h0ABCDEF1);
        run_uinstr(16'h0000, 1'b0, 0);             // -> 0
        rom[0]  = mk(DISP, 1'b0, 8'd64, 29'h1F00FF00);
        rom[67] = mk(JMP, 1'b0, 8'd0, 29'h00000033);
        rom[66] = mk(JMP, 1'b0, 8'd0, 29'h1FFFFFFF);
        run_uinstr(16'h8600, 1'b0, 0);             // -> 67
        run_uinstr(16'h0000, 1'b0, 0);             // -> 0
        run_uinstr(16'h4000, 1'b0, 0);             // -> 66
        run_uinstr(16'h0000, 1'b0, 0);             // -> 0

        // Conditional jump both ways.
        rom[0]  = mk(JMP, 1'b0, 8'd5, 29'h00001234);
        rom[5]  = mk(CJ,  1'b0, 8'd20, 29'h1555AAAA);
        rom[20] = mk(JMP, 1'b0, 8'd5, 29'h0000F00F);
        run_uinstr(16'h0000, 1'b0, 0);             // -> 5
        run_uinstr(16'h0000, 1'b1, 0);             // -> 20
        run_uinstr(16'h0000, 1'b0, 0);             // -> 5
        run_uinstr(16'h0000, 1'b0, 0);             // -> 6

        // Stall: three not-ready M cycles, five cycles total.
        rom[6] = mk(SEQ, 1'b1, 8'd0, '1);
        run_uinstr(16'h0000, 1'b0, 3);             // -> 7

        // Wrap from 255 to 0, then halt at 9.
        rom[7]   = mk(JMP, 1'b0, 8'd255, 29'h00000001);
        rom[255] = mk(SEQ, 1'b0, 8'd0, 29'h1FFFFFFF);
        run_uinstr(16'h0000, 1'b0, 0);             // -> 255
        run_uinstr(16'h0000, 1'b0, 0);             // -> 0
        rom[0] = mk(JMP, 1'b0, 8'd9, 29'h00000002);
        rom[9] = mk(JMP, 1'b0, 8'd9, '1);
        run_uinstr(16'h0000, 1'b0, 0);             // -> 9
        repeat (4) run_uinstr(16'h0000, 1'b1, 0);  // stays at 9

        // Reset during the second stalled M cycle.
        rom[9] = mk(SEQ, 1'b1, 8'd0, '1);
        rom[0] = mk(SEQ, 1'b1, 8'd0, 29'h1ABCDEF0);
        mem_ready = 1'b1;
        #1 expect_cycle("rs_setup", 0, 1'b0, rom[9], 1);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        #1 expect_cycle("rs_stall", 1, 1'b0, rom[9], 1);
        @(posedge clk); #1;
        reset = 1'b0;
        mem_ready = 1'b1;
        #1 expect_reset("rs_reset");
        $display("uinstr upc=9 abandoned by reset");
        @(posedge clk); #1;
        reset = 1'b1;
        m_upc = 0;
        run_uinstr(16'h0000, 1'b0, 1);             // -> 1

        // Randomized program and inputs.
        for (int i = 0; i < DEPTH; i++) begin
            rnd = {$urandom(), $urandom()};
            rom[i] = rnd[UW-1:0];
        end
        repeat (200) begin
            run_uinstr(IW'($urandom()), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
